// File: rtl/vga_write_arbiter.sv
// Arbitrates the single framebuffer write port between a full-screen clear
// engine and two pixel renderers; all outputs are registered.
module vga_write_arbiter #(
   parameter int SCREEN_W = 160,
   parameter int SCREEN_H = 120
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       clear_req,
   input  logic [2:0] clear_colour,
   input  logic       req0,
   input  logic       req1,
   input  logic       done0,
   input  logic       done1,
   input  logic [7:0] x0,
   input  logic [7:0] x1,
   input  logic [6:0] y0,
   input  logic [6:0] y1,
   input  logic [2:0] c0,
   input  logic [2:0] c1,
   input  logic       we0,
   input  logic       we1,
   output logic       gnt0,
   output logic       gnt1,
   output logic       busy,
   output logic [7:0] vga_x,
   output logic [6:0] vga_y,
   output logic [2:0] vga_colour,
   output logic       vga_plot,
   output logic       clear_done
);

   // state  | meaning
   // IDLE   | port free, arbitration decided each cycle
   // CLEAR  | sweeping every pixel with clear_colour
   // OWN0   | requester 0 (board) owns the port
   // OWN1   | requester 1 (overlay) owns the port
   typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_OWN0, S_OWN1} state_t;

   localparam logic [7:0] CX_LAST = 8'(SCREEN_W - 1);
   localparam logic [6:0] CY_LAST = 7'(SCREEN_H - 1);

   state_t     r_state;
   state_t     w_next;
   logic       r_clear_pend;
   logic       r_last_served;
   logic [7:0] r_cx;
   logic [6:0] r_cy;
   logic       r_gnt0;
   logic       r_gnt1;
   logic       r_busy;
   logic [7:0] r_vga_x;
   logic [6:0] r_vga_y;
   logic [2:0] r_vga_colour;
   logic       r_vga_plot;
   logic       r_clear_done;
   logic       w_last_pix;

   assign w_last_pix = (r_cx == CX_LAST) && (r_cy == CY_LAST);

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (r_clear_pend || clear_req)  w_next = S_CLEAR;
            else if (req0 && req1)          w_next = r_last_served ? S_OWN0 : S_OWN1;
            else if (req0)                  w_next = S_OWN0;
            else if (req1)                  w_next = S_OWN1;
         end
         S_CLEAR: if (w_last_pix) w_next = S_IDLE;
         S_OWN0:  if (done0)      w_next = S_IDLE;
         S_OWN1:  if (done1)      w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state       <= S_IDLE;
         r_clear_pend  <= 1'b0;
         r_last_served <= 1'b1;
         r_cx          <= '0;
         r_cy          <= '0;
         r_gnt0        <= 1'b0;
         r_gnt1        <= 1'b0;
         r_busy        <= 1'b0;
         r_vga_x       <= '0;
         r_vga_y       <= '0;
         r_vga_colour  <= '0;
         r_vga_plot    <= 1'b0;
         r_clear_done  <= 1'b0;
      end else begin
         r_state      <= w_next;
         r_gnt0       <= (w_next == S_OWN0);
         r_gnt1       <= (w_next == S_OWN1);
         r_busy       <= (w_next != S_IDLE);
         r_clear_done <= (r_state == S_CLEAR) && w_last_pix;

         // entry into CLEAR consumes the pending request; requests during CLEAR are dropped
         if (r_state != S_CLEAR) begin
            if (w_next == S_CLEAR) r_clear_pend <= 1'b0;
            else if (clear_req)    r_clear_pend <= 1'b1;
         end

         if (r_state == S_CLEAR) begin
            if (r_cx == CX_LAST) begin
               r_cx <= '0;
               r_cy <= (r_cy == CY_LAST) ? '0 : r_cy + 7'd1;
            end else begin
               r_cx <= r_cx + 8'd1;
            end
         end else begin
            r_cx <= '0;
            r_cy <= '0;
         end

         if (r_state == S_OWN0 && done0) r_last_served <= 1'b0;
         if (r_state == S_OWN1 && done1) r_last_served <= 1'b1;

         case (r_state)
            S_CLEAR: begin
               r_vga_x      <= r_cx;
               r_vga_y      <= r_cy;
               r_vga_colour <= clear_colour;
               r_vga_plot   <= 1'b1;
            end
            S_OWN0: begin
               r_vga_x      <= x0;
               r_vga_y      <= y0;
               r_vga_colour <= c0;
               r_vga_plot   <= we0;
            end
            S_OWN1: begin
               r_vga_x      <= x1;
               r_vga_y      <= y1;
               r_vga_colour <= c1;
               r_vga_plot   <= we1;
            end
            default: r_vga_plot <= 1'b0;
         endcase
      end
   end

   assign gnt0       = r_gnt0;
   assign gnt1       = r_gnt1;
   assign busy       = r_busy;
   assign vga_x      = r_vga_x;
   assign vga_y      = r_vga_y;
   assign vga_colour = r_vga_colour;
   assign vga_plot   = r_vga_plot;
   assign clear_done = r_clear_done;

endmodule

// File: tb/tb_vga_write_arbiter.sv
// Directed bench for vga_write_arbiter: expected write-port values go into a
// scoreboard queue as stimulus is driven and are popped when the write appears.
module tb_vga_write_arbiter;

   typedef struct packed {
      logic       plot;
      logic [7:0] x;
      logic [6:0] y;
      logic [2:0] c;
   } pix_t;

   logic       clk = 1'b0;
   logic       resetn = 1'b1;
   logic       clear_req = 1'b0;
   logic [2:0] clear_colour = '0;
   logic       req0 = 1'b0, req1 = 1'b0, done0 = 1'b0, done1 = 1'b0;
   logic [7:0] x0 = '0, x1 = '0;
   logic [6:0] y0 = '0, y1 = '0;
   logic [2:0] c0 = '0, c1 = '0;
   logic       we0 = 1'b0, we1 = 1'b0;
   logic       gnt0, gnt1, busy, vga_plot, clear_done;
   logic [7:0] vga_x;
   logic [6:0] vga_y;
   logic [2:0] vga_colour;

   pix_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;

   vga_write_arbiter dut (
      .clk(clk), .resetn(resetn), .clear_req(clear_req), .clear_colour(clear_colour),
      .req0(req0), .req1(req1), .done0(done0), .done1(done1),
      .x0(x0), .x1(x1), .y0(y0), .y1(y1), .c0(c0), .c1(c1), .we0(we0), .we1(we1),
      .gnt0(gnt0), .gnt1(gnt1), .busy(busy),
      .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
      .clear_done(clear_done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic p, input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
      pix_t e;
      e.plot = p; e.x = x; e.y = y; e.c = c;
      sb.push_back(e);
   endtask

   task automatic chk_vga(input string tag);
      pix_t e;
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         chk(tag, {vga_plot, vga_x, vga_y, vga_colour}, e);
      end
   endtask

   task automatic chk_ctl(input string tag, input logic g0, input logic g1, input logic b);
      chk(tag, {gnt0, gnt1, busy}, {g0, g1, b});
   endtask

   initial begin
      // asynchronous reset, checked before any clock edge
      #2 resetn = 1'b0;
      #2;
      chk("reset_outs", {gnt0, gnt1, busy, vga_plot, vga_x, vga_y, vga_colour, clear_done}, '0);
      tick(); tick();
      resetn = 1'b1;
      tick();
      chk("post_reset_idle", {gnt0, gnt1, busy, vga_plot, clear_done}, '0);

      // first tie goes to requester 0
      req0 = 1'b1; req1 = 1'b1;
      tick();
      chk_ctl("tie_first_gnt0", 1, 0, 1);
      chk("grant_cycle_noplot", vga_plot, 0);

      x0 = 8'd25; y0 = 7'd14; c0 = 3'b100; we0 = 1'b1;
      x1 = 8'd99; y1 = 7'd3;  c1 = 3'b111; we1 = 1'b1;
      push(1, 8'd25, 7'd14, 3'b100);
      tick();
      chk_vga("own0_write");
      chk_ctl("own0_hold", 1, 0, 1);

      // done1 while requester 0 owns: ignored; x1/c1 changes invisible
      x1 = 8'd50; c1 = 3'b010; done1 = 1'b1; we0 = 1'b0;
      push(0, 8'd25, 7'd14, 3'b100);
      tick();
      chk_vga("own0_nowe");
      chk_ctl("done1_ignored", 1, 0, 1);

      // release with a final write
      done1 = 1'b0; done0 = 1'b1;
      x0 = 8'd30; y0 = 7'd5; c0 = 3'b010; we0 = 1'b1;
      push(1, 8'd30, 7'd5, 3'b010);
      tick();
      chk_vga("own0_last_write");
      chk_ctl("own0_released", 0, 0, 0);

      done0 = 1'b0;
      push(0, 8'd30, 7'd5, 3'b010);
      tick();
      chk_ctl("tie_second_gnt1", 0, 1, 1);
      chk_vga("idle_hold");

      // clear request during OWN1 must wait
      clear_req = 1'b1;
      x1 = 8'd7; y1 = 7'd8; c1 = 3'b001; we1 = 1'b1;
      push(1, 8'd7, 7'd8, 3'b001);
      tick();
      chk_vga("own1_write");
      chk_ctl("clear_no_preempt", 0, 1, 1);

      clear_req = 1'b0; done1 = 1'b1; we1 = 1'b0;
      push(0, 8'd7, 7'd8, 3'b001);
      tick();
      chk_vga("own1_release");
      chk_ctl("own1_released", 0, 0, 0);

      done1 = 1'b0;
      tick();
      chk_ctl("clear_before_req0", 0, 0, 1);
      chk("clear_entry_noplot", vga_plot, 0);

      // full sweep; a clear_req mid-sweep must be ignored
      for (int i = 0; i < 19200; i++) begin
         clear_colour = 3'($urandom_range(0, 7));
         clear_req = (i == 9000);
         push(1, 8'(i % 160), 7'(i / 160), clear_colour);
         tick();
         chk_vga("clear_pixel");
         if (i == 19199) chk("clear_done_pulse", {clear_done, busy}, 2'b10);
         else            chk("clear_running", {clear_done, busy}, 2'b01);
      end
      clear_req = 1'b0;

      tick();
      chk_ctl("after_clear_gnt0", 1, 0, 1);
      chk("clear_done_single", {clear_done, vga_plot}, 2'b00);

      done0 = 1'b1; we0 = 1'b0;
      push(0, 8'd30, 7'd5, 3'b010);
      tick();
      chk_vga("own0_release2");
      done0 = 1'b0;
      tick();
      chk_ctl("tie_after0_gnt1", 0, 1, 1);
      done1 = 1'b1;
      tick();
      chk_ctl("own1_released2", 0, 0, 0);
      done1 = 1'b0;
      tick();
      chk_ctl("tie_after1_gnt0", 1, 0, 1);
      done0 = 1'b1;
      tick();
      done0 = 1'b0; req0 = 1'b0; req1 = 1'b0;
      tick();
      chk_ctl("all_released", 0, 0, 0);

      // reset in the middle of a clear sweep
      clear_req = 1'b1; clear_colour = 3'b101;
      tick();
      clear_req = 1'b0;
      for (int i = 0; i < 40 * 160 + 61; i++) tick();
      chk("clear_at_60_40", {vga_plot, vga_x, vga_y, vga_colour}, {1'b1, 8'd60, 7'd40, 3'b101});
      resetn = 1'b0;
      #1;
      chk("mid_clear_reset", {gnt0, gnt1, busy, vga_plot, vga_x, vga_y, vga_colour, clear_done}, '0);
      tick();
      resetn = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("no_resume", {vga_plot, busy, clear_done, gnt0, gnt1}, '0);
      end

      chk("scoreboard_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/vga_write_arbiter.md
VGA_WRITE_ARBITER -- requirements
Module: vga_write_arbiter

Interface
REQ-001 Parameter: SCREEN_W, default 160, pixel columns swept by clear.
REQ-002 Parameter: SCREEN_H, default 120, pixel rows swept by clear.
REQ-003 Port: clk  in  1  system clock, all state on rising edge.
REQ-004 Port: resetn  in  1  asynchronous, active-low reset.
REQ-005 Port: clear_req  in  1  request full-screen clear, sampled each cycle.
REQ-006 Port: clear_colour  in  3  fill colour, sampled on every clear write cycle.
REQ-007 Port: req0 / req1  in  1  requester 0 (board renderer) / 1 (overlay/banner renderer) wants the write port.
REQ-008 Port: done0 / done1  in  1  requester releases port; honoured only while granted.
REQ-009 Port: x0, x1  in  8; y0, y1  in  7; c0, c1  in  3; we0, we1  in  1  requester pixel address, colour and write enable.
REQ-010 Port: gnt0 / gnt1  out  1  registered grant, at most one high.
REQ-011 Port: busy  out  1  high in any state other than IDLE.
REQ-012 Port: vga_x  out  8; vga_y  out  7; vga_colour  out  3; vga_plot  out  1  registered framebuffer write port.
REQ-013 Port: clear_done  out  1  one-cycle pulse after last clear pixel.

Function
REQ-014 FSM states: IDLE, CLEAR, OWN0, OWN1.
REQ-015 clear_pend sets on any cycle with clear_req=1 outside CLEAR; it clears on entry to CLEAR; clear_req during CLEAR is ignored.
REQ-016 IDLE priority: clear_pend (or clear_req this cycle) -> CLEAR; else single requester -> its OWN state; else both -> requester not equal to last_served.
REQ-017 gnt_n is high exactly while state = OWN_n, asserted the cycle after the IDLE decision edge.
REQ-018 In OWN_n: vga_x/vga_y/vga_colour/vga_plot = xn/yn/cn/wen registered; one-cycle latency.
REQ-019 In OWN_n with done_n=1: next state IDLE, last_served<=n, gnt_n low next cycle; a write presented with done_n is still issued.
REQ-020 done_n while not granted: ignored, no state change.
REQ-021 Non-granted requester's inputs never reach vga_* outputs.
REQ-022 In IDLE: vga_plot=0; vga_x/vga_y/vga_colour hold last values.
REQ-023 CLEAR: counters cx (0..SCREEN_W-1), cy (0..SCREEN_H-1), start at (0,0); cx increments every cycle, wraps to 0 with cy+1.
REQ-024 CLEAR output: vga_plot=1, vga_x=cx, vga_y=cy, vga_colour=clear_colour every cycle; total SCREEN_W*SCREEN_H writes.
REQ-025 After write (SCREEN_W-1,SCREEN_H-1): next state IDLE, clear_done=1 for exactly that following cycle.
REQ-026 At least one IDLE cycle between any two ownerships; no back-to-back grants.
REQ-027 Requests arriving while another owner holds the port wait; no preemption, including clear.
REQ-028 Counter widths: cx 8 bit, cy 7 bit; no overflow for default parameters.

Reset
REQ-029 resetn=0 asynchronously forces: state IDLE, gnt0=gnt1=0, busy=0, vga_plot=0, vga_x=0, vga_y=0, vga_colour=0, clear_done=0, clear_pend=0, cx=cy=0, last_served=1 (first tie goes to requester 0).
REQ-030 Reset mid-CLEAR or mid-ownership aborts; no clear_done, no resumption after release.

Verification
REQ-031 clear_req pulse from IDLE -> 19200 consecutive plot cycles covering (0,0)..(159,119) row-major with clear_colour, then clear_done one cycle, busy low.
REQ-032 req0=req1=1 simultaneously after reset -> gnt0 first; after done0 one IDLE cycle, then gnt1; next tie after done1 -> gnt0.
REQ-033 In OWN0, x0=25,y0=14,c0=3'b100,we0=1 -> next cycle vga_x=25, vga_y=14, vga_colour=3'b100, vga_plot=1; x1/c1 changes have no effect.
REQ-034 clear_req during OWN1 -> no preemption; after done1, CLEAR entered before a waiting req0 is granted.
REQ-035 resetn low at clear pixel (60,40) -> all outputs 0 immediately; after release, IDLE, no clear_done, no further plots without new request.
REQ-036 done1 asserted while gnt0 high -> ignored; OWN0 continues until done0.
